mult_sequencer: RTL and testbench
=================================

# mult_sequencer

Iterative multiply sequencer that owns the HI/LO register pair for the MIPS pipeline. It accepts the `start_mult` and `mult_sign` strobes produced by the main decoder for MULT/MULTU, runs a radix-2 shift-add multiply over several cycles, and writes the 64-bit product into HI/LO. While a multiply is in flight it holds the pipeline off any MFHI/MFLO read.

## Interface
- `DATA_W`, default 32: operand width; HI and LO are each `DATA_W` bits wide.
- `clk`  in  1  single system clock; all state updates on its rising edge.
- `rst_n`  in  1  synchronous reset, active-low.
- `start_mult`  in  1  decoder strobe for MULT/MULTU, sampled on the rising edge.
- `mult_sign`  in  1  1 = signed (MULT), 0 = unsigned (MULTU); sampled together with `start_mult`.
- `src_a`  in  DATA_W  multiplicand (rs value); sampled together with `start_mult`.
- `src_b`  in  DATA_W  multiplier (rt value); sampled together with `start_mult`.
- `hilo_rd`  in  1  the instruction in decode is MFHI or MFLO.
- `busy`  out  1  registered; high while a multiply is in flight.
- `done`  out  1  registered; one-cycle pulse when HI/LO are updated.
- `stall`  out  1  combinational; equals `hilo_rd & busy`.
- `hi`  out  DATA_W  upper product word (registered).
- `lo`  out  DATA_W  lower product word (registered).

## Operation
- States: IDLE, RUN, FIX.
- **IDLE, start accepted** (`start_mult`=1):
  - Latch `mcand` = |src_a| zero-extended to 2·DATA_W bits, and `mplier` = |src_b|.
  - Magnitudes are taken only when `mult_sign`=1; otherwise the operands are used as-is.
  - Latch `neg` = `mult_sign` & (src_a MSB ^ src_b MSB).
  - Clear `acc`, set `count`=0, go to RUN.
  - Magnitude of the most-negative value (0x80000000) is 0x80000000 as unsigned; no overflow.
- **RUN**, each cycle:
  - If `mplier[0]`, `acc` += `mcand`, computed in 2·DATA_W bits.
  - `mcand` <<= 1; `mplier` >>= 1; `count`++.
  - After the iteration with `count` = DATA_W−1, go to FIX.
- **FIX**:
  - `{hi,lo}` = `neg` ? −`acc` : `acc`, in two's complement, 2·DATA_W bits.
  - Pulse `done`; go to IDLE.
- `start_mult` in RUN or FIX aborts the current operation and restarts with the new operands, using the same latch actions as in IDLE. HI/LO are not written by the aborted operation.
- `hi`/`lo` change only in FIX or on reset.
- Reset (`rst_n`=0 at an edge), including mid-operation: state → IDLE; `hi`=0, `lo`=0, `busy`=0, `done`=0; `acc`, `mcand`, `mplier`, `count`, `neg` cleared.

## Timing
- Start sampled at edge E0.
- RUN iterations occur at edges E1..E32, with DATA_W=32.
- FIX writes HI/LO at edge E33.
- `busy` is 1 from after E0 through E33 and 0 after E33.
- `done` is 1 for the cycle after E33.
- Fixed latency: 33 cycles from start to HI/LO valid.
- `stall` has zero latency. An MFHI/MFLO decoded in the cycle after E33 is not stalled and reads the new value.

## Configuration
- Macro: `MULT_EARLY_TERM_EN`.
- Defined: in RUN, if the value of `mplier` after the shift is 0, go to FIX on that edge regardless of `count`.
  - Latency becomes (index of highest set bit of |src_b|) + 2 cycles.
  - A zero multiplier still takes 1 RUN cycle plus FIX.
  - The result is bit-identical to the fixed-latency result.
- Undefined: fixed DATA_W+1 cycle latency as described above.

## Structure
- Package `mult_pkg`: state enum (IDLE/RUN/FIX), `DATA_W` default constant, and the count width `$clog2(DATA_W)+1`.
- Sub-module `mult_datapath`: holds `acc`, `mcand`, `mplier` and the FIX negation, driven by load/step/commit controls.
- The FSM, count, `busy`, `done` and `stall` stay in `mult_sequencer`.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001; `done` 33 cycles after start; `busy` high for exactly 33 cycles.
- MULT −3 × 5 (0xFFFFFFFD, 0x00000005) → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1. Same operands as MULTU → `hi`=0x00000004, `lo`=0xFFFFFFF1.
- MULT 0x80000000 × 0x80000000 → `hi`=0x40000000, `lo`=0x00000000. MULT 0x80000000 × 0x00000001 → `hi`=0xFFFFFFFF, `lo`=0x80000000.
- Start 7×9, then restart with 2×3 at cycle 10 → single `done` 33 cycles after the restart; `hi`=0, `lo`=6; the value 63 never appears.
- `hilo_rd`=1 throughout a multiply → `stall`=1 exactly while `busy`=1. Assert `rst_n`=0 at cycle 15 → next cycle `busy`=0, `hi`=`lo`=0, no `done`.
- With `MULT_EARLY_TERM_EN`: MULTU 0x12345678 × 1 → `done` 2 cycles after start, `lo`=0x12345678. Repeat all vectors above with identical results.

Source files
------------

// File: rtl/mult_pkg.sv
// ============================================================================
// Module   : mult_pkg
// Purpose  : Shared definitions for the HI/LO multiply sequencer: the FSM state
//            encoding, the default operand width and the iteration-counter
//            width helper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mult_pkg;

  // Default operand width. HI and LO are each this wide.
  localparam int MULT_DATA_W = 32;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

  // The counter must hold values 0..width-1 with headroom for the increment
  // performed on the final iteration.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

  localparam int MULT_CNT_W = cnt_width(MULT_DATA_W);

endpackage : mult_pkg

`default_nettype wire

// File: rtl/mult_datapath.sv
// ============================================================================
// Module   : mult_datapath
// Purpose  : Radix-2 shift-add datapath for the multiply sequencer. Holds the
//            accumulator, shifted multiplicand, shifted multiplier, the result
//            sign and the architectural HI/LO pair.
// Ports    : clk_i          - system clock
//            rst_ni         - synchronous reset, active low
//            load_i         - latch operand magnitudes, clear accumulator
//            step_i         - perform one shift-add iteration
//            commit_i       - write (optionally negated) accumulator to HI/LO
//            sign_i         - operands are signed (MULT) when high
//            src_a_i        - multiplicand
//            src_b_i        - multiplier
//            mplier_last_o  - multiplier becomes zero after the current shift
//            hi_o / lo_o    - product words
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_datapath
  import mult_pkg::*;
#(
  parameter int DATA_W = MULT_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic              step_i,
  input  logic              commit_i,
  input  logic              sign_i,
  input  logic [DATA_W-1:0] src_a_i,
  input  logic [DATA_W-1:0] src_b_i,
  output logic              mplier_last_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam int PROD_W = 2 * DATA_W;

  logic [PROD_W-1:0] acc_q,    acc_d;
  logic [PROD_W-1:0] mcand_q,  mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic              neg_q,    neg_d;
  logic [DATA_W-1:0] hi_q,     hi_d;
  logic [DATA_W-1:0] lo_q,     lo_d;

  logic [DATA_W-1:0] a_mag;
  logic [DATA_W-1:0] b_mag;
  logic [PROD_W-1:0] result;

  // Magnitudes only for signed operands. The most-negative value negates to
  // itself, which read as unsigned is exactly its magnitude.
  assign a_mag  = (sign_i && src_a_i[DATA_W-1]) ? -src_a_i : src_a_i;
  assign b_mag  = (sign_i && src_b_i[DATA_W-1]) ? -src_b_i : src_b_i;
  assign result = neg_q ? -acc_q : acc_q;

  // Looks at the multiplier as it will be after this cycle's shift.
  assign mplier_last_o = (mplier_q[DATA_W-1:1] == '0);

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    // Load has priority so that a restart discards any in-flight work.
    if (load_i) begin
      acc_d    = '0;
      mcand_d  = {{DATA_W{1'b0}}, a_mag};
      mplier_d = b_mag;
      neg_d    = sign_i & (src_a_i[DATA_W-1] ^ src_b_i[DATA_W-1]);
    end else if (step_i) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
    end else if (commit_i) begin
      {hi_d, lo_d} = result;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule : mult_datapath

`default_nettype wire

// File: rtl/mult_sequencer.sv
// ============================================================================
// Module   : mult_sequencer
// Purpose  : Iterative MULT/MULTU sequencer owning the HI/LO register pair.
//            Runs a radix-2 shift-add multiply and stalls MFHI/MFLO reads
//            while a multiply is in flight.
// Config   : MULT_EARLY_TERM_EN - when defined, the multiply finishes as soon
//            as the remaining multiplier bits are all zero.
// Ports    : clk_i        - system clock, rising edge
//            rst_ni       - synchronous reset, active low
//            start_mult_i - start strobe (restarts if already running)
//            mult_sign_i  - 1 = MULT (signed), 0 = MULTU
//            src_a_i      - multiplicand (rs)
//            src_b_i      - multiplier (rt)
//            hilo_rd_i    - MFHI/MFLO in decode
//            busy_o       - multiply in flight (registered)
//            done_o       - one-cycle pulse after HI/LO update (registered)
//            stall_o      - hilo_rd_i & busy_o (combinational)
//            hi_o / lo_o  - product words (registered)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_sequencer
  import mult_pkg::*;
#(
  parameter int DATA_W = MULT_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_mult_i,
  input  logic              mult_sign_i,
  input  logic [DATA_W-1:0] src_a_i,
  input  logic [DATA_W-1:0] src_b_i,
  input  logic              hilo_rd_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              stall_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam int CNT_W = cnt_width(DATA_W);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

`ifdef MULT_EARLY_TERM_EN
  localparam bit EARLY_TERM = 1'b1;
`else
  localparam bit EARLY_TERM = 1'b0;
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;

  logic load;
  logic step;
  logic commit;
  logic mplier_last;
  logic last_iter;

  // The final RUN iteration is either the fixed one, or (with early
  // termination) the one that shifts out the last set multiplier bit.
  assign last_iter = (count_q == LAST_ITER) || (EARLY_TERM && mplier_last);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    load    = 1'b0;
    step    = 1'b0;
    commit  = 1'b0;

    unique case (state_q)
      IDLE: begin
      end
      RUN: begin
        step    = 1'b1;
        count_d = count_q + 1'b1;
        if (last_iter) begin
          state_d = FIX;
        end
      end
      FIX: begin
        commit  = 1'b1;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // A start in any state (re)loads operands and suppresses the commit of
    // the operation it replaces.
    if (start_mult_i) begin
      load    = 1'b1;
      step    = 1'b0;
      commit  = 1'b0;
      done_d  = 1'b0;
      busy_d  = 1'b1;
      count_d = '0;
      state_d = RUN;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  mult_datapath #(
    .DATA_W (DATA_W)
  ) u_datapath (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .load_i        (load),
    .step_i        (step),
    .commit_i      (commit),
    .sign_i        (mult_sign_i),
    .src_a_i       (src_a_i),
    .src_b_i       (src_b_i),
    .mplier_last_o (mplier_last),
    .hi_o          (hi_o),
    .lo_o          (lo_o)
  );

  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign stall_o = hilo_rd_i & busy_q;

endmodule : mult_sequencer

`default_nettype wire

// File: tb/tb_mult_sequencer.sv
// ============================================================================
// Module   : tb_mult_sequencer
// Purpose  : Self-checking bench for mult_sequencer (DATA_W = 32). Expected
//            products are queued when a multiply is started and compared when
//            done_o pulses; latency, busy length, stall and HI/LO hold are
//            checked along the way. Honours MULT_EARLY_TERM_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_mult;
  logic        mult_sign;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        hilo_rd;
  logic        busy;
  logic        done;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int          vectors    = 0;
  int          miscompares = 0;
  logic [63:0] sb[$];
  logic [63:0] prev_hilo  = '0;

  mult_sequencer #(
    .DATA_W (32)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_mult_i (start_mult),
    .mult_sign_i  (mult_sign),
    .src_a_i      (src_a),
    .src_b_i      (src_b),
    .hilo_rd_i    (hilo_rd),
    .busy_o       (busy),
    .done_o       (done),
    .stall_o      (stall),
    .hi_o         (hi),
    .lo_o         (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input bit s, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sbv;
    if (s) begin
      sa  = $signed({{32{a[31]}}, a});
      sbv = $signed({{32{b[31]}}, b});
      return sa * sbv;
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  // Edges from the start edge to the HI/LO write edge.
  function automatic int lat_of(input bit s, input logic [31:0] b);
`ifdef MULT_EARLY_TERM_EN
    logic [31:0] m;
    m = (s && b[31]) ? -b : b;
    for (int i = 31; i >= 0; i--) begin
      if (m[i]) return i + 2;
    end
    return 2;
`else
    if (s || b[0] || !b[0]) return 33;
    return 33;
`endif
  endfunction

  // Starts one multiply and follows it to done, checking along the way.
  task automatic run_op(input bit s, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input bit rd);
    int          lat_exp;
    int          n;
    int          busy_cnt;
    bit          got;
    logic [63:0] res;
    sb.push_back(exp);
    lat_exp    = lat_of(s, b);
    start_mult = 1'b1;
    mult_sign  = s;
    src_a      = a;
    src_b      = b;
    hilo_rd    = rd;
    @(negedge clk);
    start_mult = 1'b0;
    n          = 1;
    busy_cnt   = 0;
    got        = 1'b0;
    while (!got && n <= 100) begin
      if (done === 1'b1) begin
        if (sb.size() > 0) res = sb.pop_front();
        else res = 'x;
        check("hilo", {hi, lo}, res);
        check("latency", 64'(n - 1), 64'(lat_exp));
        check("busy_len", 64'(busy_cnt), 64'(lat_exp));
        check("busy_off", 64'(busy), 64'd0);
        prev_hilo = res;
        got       = 1'b1;
      end else begin
        check("hilo_hold", {hi, lo}, prev_hilo);
        if (busy === 1'b1) busy_cnt++;
      end
      if (rd) check("stall", 64'(stall), 64'(n <= lat_exp));
      @(negedge clk);
      n++;
    end
    if (!got) begin
      check("timeout", 64'd0, 64'd1);
      if (sb.size() > 0) void'(sb.pop_front());
    end
    check("done_single", 64'(done), 64'd0);
    hilo_rd = 1'b0;
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    bit          rs;
    int          restart_at;

    rst_n      = 1'b0;
    start_mult = 1'b0;
    mult_sign  = 1'b0;
    src_a      = '0;
    src_b      = '0;
    hilo_rd    = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy",  64'(busy),  64'd0);
    check("rst_done",  64'(done),  64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_hilo",  {hi, lo},   64'd0);
    hilo_rd = 1'b0;
    rst_n   = 1'b1;
    @(negedge clk);

    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0);
    run_op(1'b1, 32'hFFFF_FFFD, 32'h0000_0005, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0);
    run_op(1'b0, 32'hFFFF_FFFD, 32'h0000_0005, 64'h0000_0004_FFFF_FFF1, 1'b0);
    run_op(1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0);
    run_op(1'b1, 32'h8000_0000, 32'h0000_0001, 64'hFFFF_FFFF_8000_0000, 1'b0);
    run_op(1'b0, 32'h1234_5678, 32'h0000_0001, 64'h0000_0000_1234_5678, 1'b0);
    run_op(1'b1, 32'h0000_0005, 32'h0000_0000, 64'h0000_0000_0000_0000, 1'b0);
    run_op(1'b1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 64'hFFFF_FFFF_8000_0001, 1'b1);

    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      run_op(rs, ra, rb, model(rs, ra, rb), 1'b0);
    end

    // Restart: 7 x 9 is abandoned; its product must never reach HI/LO.
`ifdef MULT_EARLY_TERM_EN
    restart_at = 2;
`else
    restart_at = 10;
`endif
    start_mult = 1'b1;
    mult_sign  = 1'b0;
    src_a      = 32'd7;
    src_b      = 32'd9;
    @(negedge clk);
    start_mult = 1'b0;
    for (int k = 1; k < restart_at; k++) begin
      check("restart_nodone", 64'(done), 64'd0);
      check("restart_hold", {hi, lo}, prev_hilo);
      @(negedge clk);
    end
    run_op(1'b0, 32'd2, 32'd3, 64'd6, 1'b0);

    // Reset mid-operation.
    start_mult = 1'b1;
    mult_sign  = 1'b0;
    src_a      = 32'h0000_1234;
    src_b      = 32'hFFFF_0000;
    @(negedge clk);
    start_mult = 1'b0;
    for (int k = 1; k < 15; k++) begin
      check("pre_rst_nodone", 64'(done), 64'd0);
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_hilo", {hi, lo},  64'd0);
    rst_n     = 1'b1;
    prev_hilo = '0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      check("post_rst_nodone", 64'(done), 64'd0);
    end
    check("post_rst_busy", 64'(busy), 64'd0);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_mult_sequencer

`default_nettype wire
